// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file access controller.
package regfile_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/regfile_access_ctrl_arb.sv
// Two-way round-robin grant: the requester that did not win last time takes a tie.
module rr_arbiter_2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c    = '0;
    grant_c[0] = req_valid[0] & (~req_valid[1] | last_grant);
    grant_c[1] = req_valid[1] & (~req_valid[0] | ~last_grant);
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Multicycle read/write sequencer with 2-way arbitration in front of the register file.
// Operands are captured before the write commits, so rs/rt always return pre-write values.
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned ZERO_RO = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*ADDR_W-1:0]   req_rs,
  input  logic [2*ADDR_W-1:0]   req_rt,
  input  logic [2*ADDR_W-1:0]   req_rd,
  input  logic [1:0]            req_we,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_rdata_a,
  output logic [DATA_W-1:0]     rsp_rdata_b,
  output logic [ADDR_W-1:0]     rf_rs,
  output logic [ADDR_W-1:0]     rf_rt,
  output logic [ADDR_W-1:0]     rf_rd,
  output logic                  rf_we,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [DATA_W-1:0]     rf_rdata_a,
  input  logic [DATA_W-1:0]     rf_rdata_b,
  output logic                  busy
);

  localparam int unsigned CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_WAIT - 1);

  state_e              state_q, state_d;
  logic                last_grant_q;
  logic [1:0]          grant_c;
  logic                accept_c, read_last_c, sel_c, sel_we_eff_c;
  logic [ADDR_W-1:0]   sel_rs_c, sel_rt_c, sel_rd_c;
  logic [DATA_W-1:0]   sel_wdata_c;
  logic [CNT_W-1:0]    cnt_q;
  logic                lat_we_q, lat_id_q;
  logic [ADDR_W-1:0]   lat_rs_q, lat_rt_q, lat_rd_q;
  logic [DATA_W-1:0]   lat_wdata_q, opa_q, opb_q;

  rr_arbiter_2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  // Request fields of the requester currently being granted
  always_comb begin
    sel_c        = grant_c[REQ_DBG];
    sel_rs_c     = sel_c ? req_rs[2*ADDR_W-1:ADDR_W]    : req_rs[ADDR_W-1:0];
    sel_rt_c     = sel_c ? req_rt[2*ADDR_W-1:ADDR_W]    : req_rt[ADDR_W-1:0];
    sel_rd_c     = sel_c ? req_rd[2*ADDR_W-1:ADDR_W]    : req_rd[ADDR_W-1:0];
    sel_wdata_c  = sel_c ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    sel_we_eff_c = req_we[sel_c] && !((ZERO_RO != 0) && (sel_rd_c == '0));
    accept_c     = (state_q == IDLE) && (grant_c != 2'b00);
    read_last_c  = (state_q == READ) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c)    state_d = READ;
      READ:    if (read_last_c) state_d = lat_we_q ? WRITE : RESP;
      WRITE:                    state_d = RESP;
      RESP:    if (rsp_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rf_we     = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = grant_c;
        busy      = 1'b0;
      end
      WRITE:   rf_we     = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch, wait counter, operand capture and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      lat_we_q     <= 1'b0;
      lat_id_q     <= REQ_CORE;
      lat_rs_q     <= '0;
      lat_rt_q     <= '0;
      lat_rd_q     <= '0;
      lat_wdata_q  <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
    end else begin
      if (accept_c) begin
        cnt_q       <= '0;
        lat_we_q    <= sel_we_eff_c;
        lat_id_q    <= sel_c ? REQ_DBG : REQ_CORE;
        lat_rs_q    <= sel_rs_c;
        lat_rt_q    <= sel_rt_c;
        lat_rd_q    <= sel_rd_c;
        lat_wdata_q <= sel_wdata_c;
      end
      if (state_q == READ) cnt_q <= cnt_q + CNT_W'(1);
      if (read_last_c) begin
        opa_q <= rf_rdata_a;
        opb_q <= rf_rdata_b;
      end
      if ((state_q == RESP) && rsp_ready) last_grant_q <= lat_id_q;
    end
  end

  assign rf_rs       = lat_rs_q;
  assign rf_rt       = lat_rt_q;
  assign rf_rd       = lat_rd_q;
  assign rf_wdata    = lat_wdata_q;
  assign rsp_id      = lat_id_q;
  assign rsp_rdata_a = opa_q;
  assign rsp_rdata_b = opb_q;

endmodule
